arb4_rr: RTL
============

# arb4_rr

Round-robin arbiter for four producer channels. It drives the 2-bit `select` of the downstream 4-input mux (`Mux4`) and the valid/ready handshake toward the consumer. It holds the selection stable for each transfer and acknowledges the winning producer when the consumer accepts. It sits directly upstream of `Mux4`: producers present data on `din1..din4`, and this block decides which one passes.

## Interface
- `CNT_W`, default 16: width of each per-channel grant counter. Only used with `ARB4_STATS_EN`.
- `clk`  in  1: single clock. All state changes on its rising edge.
- `rst_n`  in  1: reset, asynchronous and active-low.
- `req`  in  4: `req[i]` high means channel i (mux input `din{i+1}`) holds a valid item. It stays high until acknowledged.
- `ack`  out  4: one-hot, combinational. `ack[i]` = transfer this cycle from channel i.
- `select`  out  2: registered mux select. Drives `Mux4.select`.
- `out_valid`  out  1: registered. The mux output is valid.
- `out_ready`  in  1: consumer accepts when `out_valid && out_ready`.
- `grant_cnt`  out  4×`CNT_W`: per-channel transfer counts. Present only with `ARB4_STATS_EN`.

## Operation
- States:
  - IDLE: no grant held.
  - GRANT: `select` and `out_valid` are held.
- Reset values: state=IDLE, `select`=0, `out_valid`=0, `ack`=0, `ptr`=0, `grant_cnt`=0.
- `ptr` (2 bits) is the highest-priority channel. Search order is `ptr`, `ptr+1`, `ptr+2`, `ptr+3`, taken mod 4.
- IDLE:
  - If any `req` bit is set, register `select` = first set channel in search order.
  - Set `out_valid`=1 and go to GRANT.
  - Otherwise stay in IDLE.
- GRANT:
  - While `out_ready`=0, hold `select` and `out_valid`. Changes on `req` are ignored.
  - Transfer cycle (`out_ready`=1):
    - `ack[select]`=1 and `ptr` ← `select+1` (wraps 3→0).
    - Re-arbitrate in the same cycle over `req` with `req[select]` masked, searching from `select+1`.
    - If a winner exists: `select` ← winner, stay in GRANT, `out_valid` stays 1 (back-to-back).
    - If no winner: go to IDLE and `out_valid` ← 0.
- The channel just served is always excluded from same-cycle re-arbitration. A lone requester therefore gets at most one transfer every 2 cycles, and no channel can starve.
- Protocol rule: a producer must not drop `req[i]` while granted and not yet acknowledged. The block does not check this. The grant is held regardless, and the bench asserts the rule.
- `ack` is never asserted outside a transfer cycle and is always zero or one-hot.

## Timing
- Request seen in IDLE → `select`/`out_valid` valid on the next edge. Latency is 1 cycle.
- Grant to transfer depends only on `out_ready`. `ack` is a same-cycle combinational function of state and `out_ready`.
- Contended channels: a new grant on every cycle that `out_ready` is high.
- Reset asserted mid-transfer: all outputs return to reset values immediately (asynchronously). The pending item is not acknowledged, and its producer keeps it.

## Configuration
- `ARB4_STATS_EN` defined:
  - Adds the `grant_cnt` port and four `CNT_W`-bit counters.
  - `grant_cnt[i]` increments on each transfer from channel i.
  - Counters saturate at 2^CNT_W−1 and clear only on reset.
- `ARB4_STATS_EN` undefined: no port, no counters. Arbitration behaviour is identical.

## Structure
- Package `arb4_pkg`:
  - `N_CH`=4, `SEL_W`=2.
  - `arb_state_t` enum {IDLE, GRANT}.
  - Function `rr_next(req, start)` returning winner and found flag.
- Sub-module `rr_pick4`:
  - Combinational round-robin picker: inputs 4-bit request and 2-bit start, outputs 2-bit index and `found`.
  - One instance is used in both IDLE and transfer-cycle arbitration; the caller applies the mask.
- Bench instantiates `arb4_rr` + `Mux4` (WIDTH=8) together.

## Test plan
- **Reset:** `req`=4'b1111 while `rst_n`=0 → `out_valid`=0, `select`=0, `ack`=0. After release, next edge → `select`=0, `out_valid`=1.
- **Full contention:** `req`=4'b1111 held, `out_ready`=1 → `select` sequence 0,1,2,3,0…; `ack` one-hot matches, one transfer per cycle.
- **Backpressure:** grant on channel 2, `out_ready`=0 for 5 cycles, `req` toggling on others → `select`=2 is stable, `ack`=0. Then `out_ready`=1 → `ack`=4'b0100.
- **Lone requester:** `req`=4'b1000, `out_ready`=1 → `ack[3]` every other cycle; `out_valid` pattern 1,0,1,0; `ptr` wraps 3→0.
- **Mid-transfer reset:** reset asserted while granted → outputs 0 immediately, no `ack` pulse. After reset with `req`=4'b0110 → first `select`=1.
- **With `ARB4_STATS_EN`, `CNT_W`=4:** 20 transfers from channel 0 → `grant_cnt[0]`=15 (saturated), others 0.

Source files
------------

// File: rtl/arb4_pkg.sv
// ---------------------------------------------------------------------------
// arb4_pkg
// Shared types and helpers for the four-channel round-robin arbiter.
//   N_CH        : number of producer channels
//   SEL_W       : width of a channel index / mux select
//   arb_state_t : arbiter FSM state (IDLE, GRANT)
//   pick_t      : picker result (found flag + winning index)
//   rr_next()   : first set request in search order start, start+1, ... mod N_CH
// Optional feature macro used by the top level: ARB4_STATS_EN
// ---------------------------------------------------------------------------
package arb4_pkg;

  localparam int N_CH  = 4;
  localparam int SEL_W = 2;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_t;

  typedef struct packed {
    logic             found;
    logic [SEL_W-1:0] idx;
  } pick_t;

  // Walks the search order backwards so the closest-to-start requester is the
  // last one written, which leaves it as the winner without an early exit.
  function automatic pick_t rr_next(input logic [N_CH-1:0]  req,
                                    input logic [SEL_W-1:0] start);
    pick_t            p;
    logic [SEL_W-1:0] c;
    p = '0;
    for (int k = N_CH - 1; k >= 0; k--) begin
      c = start + SEL_W'(k);
      if (req[c]) begin
        p.found = 1'b1;
        p.idx   = c;
      end
    end
    return p;
  endfunction

endpackage

// File: rtl/Mux4.sv
// ---------------------------------------------------------------------------
// Mux4
// Four-input data multiplexer steered by the arbiter's select.
//   WIDTH           : data width
//   din1..din4 in   : producer data, din{i+1} belongs to channel i
//   select     in 2 : channel to pass through
//   dout       out  : selected data
// ---------------------------------------------------------------------------
module Mux4 #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] din1,
  input  logic [WIDTH-1:0] din2,
  input  logic [WIDTH-1:0] din3,
  input  logic [WIDTH-1:0] din4,
  input  logic [1:0]       select,
  output logic [WIDTH-1:0] dout
);

  always_comb begin
    unique case (select)
      2'd0:    dout = din1;
      2'd1:    dout = din2;
      2'd2:    dout = din3;
      default: dout = din4;
    endcase
  end

endmodule

// File: rtl/rr_pick4.sv
// ---------------------------------------------------------------------------
// rr_pick4
// Combinational round-robin picker over four requests.
//   req   in  4 : request vector (caller applies any masking)
//   start in  2 : highest-priority channel for this search
//   idx   out 2 : winning channel (meaningful only when found=1)
//   found out 1 : at least one request was set
// ---------------------------------------------------------------------------
module rr_pick4
  import arb4_pkg::*;
(
  input  logic [N_CH-1:0]  req,
  input  logic [SEL_W-1:0] start,
  output logic [SEL_W-1:0] idx,
  output logic             found
);

  pick_t pick;

  assign pick  = rr_next(req, start);
  assign idx   = pick.idx;
  assign found = pick.found;

endmodule

// File: rtl/arb4_rr.sv
// ---------------------------------------------------------------------------
// arb4_rr
// Round-robin arbiter for four producers feeding Mux4. Holds the select for
// the whole transfer and acknowledges the winner when the consumer accepts.
//   CNT_W           : grant counter width (used only with ARB4_STATS_EN)
//   clk       in  1 : clock, rising edge
//   rst_n     in  1 : asynchronous active-low reset
//   req       in  4 : req[i] = channel i holds an item (held until ack[i])
//   ack       out 4 : one-hot, combinational; transfer from channel i now
//   select    out 2 : registered mux select
//   out_valid out 1 : registered; mux output is valid
//   out_ready in  1 : consumer accepts when out_valid && out_ready
//   grant_cnt out 4*CNT_W : saturating per-channel transfer counts
//                           (only when ARB4_STATS_EN is defined)
// Macro ARB4_STATS_EN adds the grant_cnt port and counters.
// ---------------------------------------------------------------------------
module arb4_rr
  import arb4_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_CH-1:0]  req,
  output logic [N_CH-1:0]  ack,
  output logic [SEL_W-1:0] select,
  output logic             out_valid,
  input  logic             out_ready
`ifdef ARB4_STATS_EN
  ,
  output logic [N_CH*CNT_W-1:0] grant_cnt
`endif
);

  arb_state_t       state_q;
  logic [SEL_W-1:0] select_q;
  logic [SEL_W-1:0] ptr_q;

  logic [N_CH-1:0]  sel_onehot;
  logic             transfer;
  logic [N_CH-1:0]  pick_req;
  logic [SEL_W-1:0] pick_start;
  logic [SEL_W-1:0] pick_idx;
  logic             pick_found;

  assign sel_onehot = N_CH'(1) << select_q;
  assign transfer   = (state_q == GRANT) && out_ready;

  // In GRANT the picker is only consulted on a transfer cycle; the served
  // channel is masked so it can never win twice in a row.
  // NOTE: every signal driven in always_comb gets a default first, so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    pick_req   = req;
    pick_start = ptr_q;
    if (state_q == GRANT) begin
      pick_req   = req & ~sel_onehot;
      pick_start = select_q + SEL_W'(1);
    end
  end

  rr_pick4 u_pick (
    .req   (pick_req),
    .start (pick_start),
    .idx   (pick_idx),
    .found (pick_found)
  );

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      select_q <= '0;
      ptr_q    <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (pick_found) begin
            select_q <= pick_idx;
            state_q  <= GRANT;
          end
        end
        GRANT: begin
          if (out_ready) begin
            ptr_q <= select_q + SEL_W'(1);
            if (pick_found) select_q <= pick_idx;  // back-to-back grant
            else            state_q  <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // out_valid is the GRANT flop itself, so it is registered and glitch-free.
  assign out_valid = (state_q == GRANT);
  assign select    = select_q;
  assign ack       = transfer ? sel_onehot : '0;

`ifdef ARB4_STATS_EN
  logic [CNT_W-1:0] cnt_q [N_CH];

  // NOTE: the counters are a handful of flops rather than a RAM, so they
  // take the asynchronous reset like the rest of the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_CH; i++) cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        if (ack[i] && (cnt_q[i] != {CNT_W{1'b1}})) cnt_q[i] <= cnt_q[i] + 1'b1;
      end
    end
  end

  for (genvar g = 0; g < N_CH; g++) begin : g_cnt_out
    assign grant_cnt[g*CNT_W +: CNT_W] = cnt_q[g];
  end
`endif

endmodule
